// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and bit-level helpers for the serial arithmetic units
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic fa_sum(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

endpackage

// File: rtl/serial_fa_slice.sv
// rtl/serial_fa_slice.sv - combinational one-bit full adder slice
module serial_fa_slice
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = fa_sum(a, b, c);
    assign co = maj(a, b, c);

endmodule

// File: rtl/serial_addsub_unit.sv
// rtl/serial_addsub_unit.sv - LSB-first bit-serial adder/subtractor with start/busy/done handshake
module serial_addsub_unit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             s_bit,
    output logic             s_valid,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_msb_in;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             shift;
    logic             finish;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    serial_fa_slice u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last_bit) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1 - borrow_in, so invert b and seed the carry with cin ^ sub.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s_valid  <= 1'b0;
            s_bit    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= cin ^ sub;
                cnt   <= '0;
                busy  <= 1'b1;
            end
            if (shift) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                res_sr  <= {fa_s, res_sr[WIDTH-1:1]};
                carry   <= fa_co;
                s_bit   <= fa_s;
                s_valid <= 1'b1;
                cnt     <= last_bit ? '0 : cnt + CW'(1);
                if (last_bit) begin
                    c_msb_in <= carry;
                end
            end
            if (finish) begin
                sum     <= res_sr;
                cout    <= carry;
                ovf     <= c_msb_in ^ carry;
                done    <= 1'b1;
                busy    <= 1'b0;
                s_valid <= 1'b0;
            end
        end
    end

endmodule
